// File: rtl/noc_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_switch_pkg
// Purpose : Shared types and width helpers for the NoC switch (allocator,
//           crossbar control, router top).
// Contents: alloc_state_t - per-output allocator state {IDLE, BUSY}
//           idx_w()       - index width for an N-entry set (min 1 bit)
// Revision: 1.0 - initial release
// ============================================================================
package noc_switch_pkg;

   typedef enum logic [0:0] {
      ALLOC_IDLE = 1'b0,
      ALLOC_BUSY = 1'b1
   } alloc_state_t;

   // Width needed to index N items; never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick. Scans ptr+1, ptr+2, ... (mod N)
//           and returns the first asserted request.
// Ports   : i_req [N]  request vector
//           i_ptr      index of the last winner (highest priority is ptr+1)
//           o_gnt [N]  one-hot grant (zero when no request)
//           o_idx      index of the winner (zero when no request)
//           o_any      at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
   import noc_switch_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int w_c;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_c   = 0;
      for (int k = 1; k <= N; k++) begin
         // Explicit wrap so N need not be a power of two.
         w_c = int'(i_ptr) + k;
         if (w_c >= N) begin
            w_c = w_c - N;
         end
         if (!o_any && i_req[w_c]) begin
            o_any      = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = IW'(w_c);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/switch_route_allocator.sv
`default_nettype none
// ============================================================================
// Module  : switch_route_allocator
// Purpose : Per-output round-robin route allocator for the mux crossbar.
//           Each free output grants one requesting input; the route is held
//           until that input's tail flit is accepted, then released.
// Ports   : clk, rst      clock / synchronous active-high reset
//           req_valid     input i has a head flit requesting an output
//           req_port      requested output of input i (slice i)
//           tail_done     tail flit of input i accepted this cycle
//           grant         input i owns a route (level)
//           grant_port    output owned by input i (valid while grant[i])
//           route_select  input index driving output o (slice o)
//           output_busy   output o reserved
// Revision: 1.0 - initial release
// ============================================================================
module switch_route_allocator
   import noc_switch_pkg::*;
#(
   parameter  int INPUTS  = 4,
   parameter  int OUTPUTS = 4,
   localparam int SEL_W   = idx_w(INPUTS),
   localparam int PORT_W  = idx_w(OUTPUTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [INPUTS-1:0]           req_valid,
   input  logic [INPUTS*PORT_W-1:0]    req_port,
   input  logic [INPUTS-1:0]           tail_done,
   output logic [INPUTS-1:0]           grant,
   output logic [INPUTS*PORT_W-1:0]    grant_port,
   output logic [OUTPUTS*SEL_W-1:0]    route_select,
   output logic [OUTPUTS-1:0]          output_busy
);

   alloc_state_t                       r_state     [OUTPUTS];
   alloc_state_t                       w_state_nxt [OUTPUTS];
   logic [OUTPUTS-1:0][SEL_W-1:0]      r_sel,   w_sel_nxt;
   logic [OUTPUTS-1:0][SEL_W-1:0]      r_ptr,   w_ptr_nxt;
   logic [OUTPUTS-1:0]                 r_busy,  w_busy_nxt;
   logic [INPUTS-1:0]                  r_grant, w_grant_nxt;
   logic [INPUTS-1:0][PORT_W-1:0]      r_gport, w_gport_nxt;

   logic [INPUTS-1:0][PORT_W-1:0]      w_rport;
   logic [OUTPUTS-1:0][INPUTS-1:0]     w_cand;
   logic [OUTPUTS-1:0][INPUTS-1:0]     w_arb_gnt;
   logic [OUTPUTS-1:0][SEL_W-1:0]      w_arb_idx;
   logic [OUTPUTS-1:0]                 w_arb_any;

   assign w_rport = req_port;

   // Already-granted inputs are excluded, so an input that releases and
   // re-requests in the same cycle competes only from the next cycle on.
   // Out-of-range req_port never equals any output index.
   always_comb begin
      w_cand = '0;
      for (int o = 0; o < OUTPUTS; o++) begin
         for (int i = 0; i < INPUTS; i++) begin
            w_cand[o][i] = req_valid[i] & ~r_grant[i] & (w_rport[i] == PORT_W'(o));
         end
      end
   end

   for (genvar g = 0; g < OUTPUTS; g++) begin : g_arb
      rr_arbiter #(.N(INPUTS)) u_arb (
         .i_req (w_cand[g]),
         .i_ptr (r_ptr[g]),
         .o_gnt (w_arb_gnt[g]),
         .o_idx (w_arb_idx[g]),
         .o_any (w_arb_any[g])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_busy_nxt  = r_busy;
      w_grant_nxt = r_grant;
      w_gport_nxt = r_gport;
      for (int o = 0; o < OUTPUTS; o++) begin
         case (r_state[o])
            ALLOC_IDLE: begin
               // Only IDLE outputs arbitrate, which gives the one-cycle
               // bubble after a release.
               if (w_arb_any[o]) begin
                  w_state_nxt[o] = ALLOC_BUSY;
                  w_sel_nxt[o]   = w_arb_idx[o];
                  w_ptr_nxt[o]   = w_arb_idx[o];
                  w_busy_nxt[o]  = 1'b1;
                  for (int i = 0; i < INPUTS; i++) begin
                     if (w_arb_gnt[o][i]) begin
                        w_grant_nxt[i] = 1'b1;
                        w_gport_nxt[i] = PORT_W'(o);
                     end
                  end
               end
            end
            ALLOC_BUSY: begin
               // route_select keeps the last owner after release.
               if (tail_done[r_sel[o]]) begin
                  w_state_nxt[o]          = ALLOC_IDLE;
                  w_busy_nxt[o]           = 1'b0;
                  w_grant_nxt[r_sel[o]]   = 1'b0;
               end
            end
            default: begin
               w_state_nxt[o] = ALLOC_IDLE;
               w_busy_nxt[o]  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < OUTPUTS; o++) begin
            r_state[o] <= ALLOC_IDLE;
         end
         r_sel   <= '0;
         r_ptr   <= {OUTPUTS{SEL_W'(INPUTS - 1)}};
         r_busy  <= '0;
         r_grant <= '0;
         r_gport <= '0;
      end else begin
         for (int o = 0; o < OUTPUTS; o++) begin
            r_state[o] <= w_state_nxt[o];
         end
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_busy  <= w_busy_nxt;
         r_grant <= w_grant_nxt;
         r_gport <= w_gport_nxt;
      end
   end

   assign grant        = r_grant;
   assign grant_port   = r_gport;
   assign route_select = r_sel;
   assign output_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_switch_route_allocator.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_route_allocator
// Purpose : Directed self-checking bench for switch_route_allocator
//           (4 inputs x 4 outputs). Expected post-edge state is queued per
//           step and compared once the DUT has registered it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_route_allocator;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] req_port;
   logic [3:0] tail_done;
   logic [3:0] grant;
   logic [7:0] grant_port;
   logic [7:0] route_select;
   logic [3:0] output_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       full;
      logic [3:0] g;
      logic [3:0] b;
      logic [7:0] rs;
      logic [7:0] gp;
   } exp_t;

   exp_t sb[$];

   switch_route_allocator #(.INPUTS(4), .OUTPUTS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_port     (req_port),
      .tail_done    (tail_done),
      .grant        (grant),
      .grant_port   (grant_port),
      .route_select (route_select),
      .output_busy  (output_busy)
   );

   always #5 clk = ~clk;

   // Queue the state expected after the next rising edge, advance one cycle,
   // then compare. Slices of idle outputs / ungranted inputs are don't-care
   // unless 'full' is set.
   task automatic cyc(input string tag, input logic full, input logic [3:0] g,
                      input logic [3:0] b, input logic [7:0] rs, input logic [7:0] gp);
      exp_t       e;
      logic [7:0] rs_m;
      logic [7:0] gp_m;
      e.tag = tag; e.full = full; e.g = g; e.b = b; e.rs = rs; e.gp = gp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      rs_m = '0;
      gp_m = '0;
      for (int k = 0; k < 4; k++) begin
         if (e.full || e.b[k]) rs_m[2*k +: 2] = 2'b11;
         if (e.full || e.g[k]) gp_m[2*k +: 2] = 2'b11;
      end
      checks++;
      assert (grant === e.g) else begin
         errors++;
         $error("FAIL %s grant observed=%b expected=%b", e.tag, grant, e.g);
      end
      checks++;
      assert (output_busy === e.b) else begin
         errors++;
         $error("FAIL %s output_busy observed=%b expected=%b", e.tag, output_busy, e.b);
      end
      checks++;
      assert ((route_select & rs_m) === (e.rs & rs_m)) else begin
         errors++;
         $error("FAIL %s route_select observed=%h expected=%h mask=%h", e.tag, route_select, e.rs, rs_m);
      end
      checks++;
      assert ((grant_port & gp_m) === (e.gp & gp_m)) else begin
         errors++;
         $error("FAIL %s grant_port observed=%h expected=%h mask=%h", e.tag, grant_port, e.gp, gp_m);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 4'b1111; req_port = 8'hAA; tail_done = 4'b0000;

      // 1: reset holds everything at zero, then input 0 wins output 2 first
      cyc("rst_a", 1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00);
      cyc("rst_b", 1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00);
      rst = 1'b0;
      cyc("first_grant", 1'b0, 4'b0001, 4'b0100, 8'h00, 8'h02);
      tail_done = 4'b0001;
      cyc("rel0", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("o2_next", 1'b0, 4'b0010, 4'b0100, 8'h10, 8'h08);
      req_valid = 4'b0000; tail_done = 4'b0010;
      cyc("rel1", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("idle1", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // 2: round robin on output 1 among inputs 0,1,3
      req_valid = 4'b1011; req_port = 8'h55;
      cyc("rr_a", 1'b0, 4'b0001, 4'b0010, 8'h00, 8'h01);
      tail_done = 4'b0001;
      cyc("rr_a_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("rr_b", 1'b0, 4'b0010, 4'b0010, 8'h04, 8'h04);
      tail_done = 4'b0010;
      cyc("rr_b_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("rr_c", 1'b0, 4'b1000, 4'b0010, 8'h0C, 8'h40);
      tail_done = 4'b1000;
      cyc("rr_c_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("rr_d", 1'b0, 4'b0001, 4'b0010, 8'h00, 8'h01);
      req_valid = 4'b0000; tail_done = 4'b0001;
      cyc("rr_d_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;

      // 3: four disjoint requests granted in parallel
      req_valid = 4'b1111; req_port = 8'h72;
      cyc("parallel", 1'b0, 4'b1111, 4'b1111, 8'h8D, 8'h72);
      cyc("par_hold", 1'b0, 4'b1111, 4'b1111, 8'h8D, 8'h72);
      req_valid = 4'b0000; tail_done = 4'b1111;
      cyc("par_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;

      // 4: tail_done on an ungranted input changes nothing
      req_valid = 4'b0010; req_port = 8'h00;
      cyc("own1", 1'b0, 4'b0010, 4'b0001, 8'h01, 8'h00);
      req_valid = 4'b0000; tail_done = 4'b0100;
      cyc("spur_a", 1'b0, 4'b0010, 4'b0001, 8'h01, 8'h00);
      cyc("spur_b", 1'b0, 4'b0010, 4'b0001, 8'h01, 8'h00);
      tail_done = 4'b0010;
      cyc("own1_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;

      // 5: release and re-request in the same cycle
      req_valid = 4'b0001; req_port = 8'h01;
      cyc("t5_own", 1'b0, 4'b0001, 4'b0010, 8'h00, 8'h01);
      tail_done = 4'b0001; req_valid = 4'b0011; req_port = 8'h05;
      cyc("t5_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;
      cyc("t5_regrant", 1'b0, 4'b0010, 4'b0010, 8'h04, 8'h04);
      req_valid = 4'b0000; tail_done = 4'b0010;
      cyc("t5_clr", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;

      // 6: reset mid-packet drops the route and restores pointer to input 0
      req_valid = 4'b0100; req_port = 8'h30;
      cyc("t6_own", 1'b0, 4'b0100, 4'b1000, 8'h80, 8'h30);
      rst = 1'b1; req_valid = 4'b0000;
      cyc("t6_rst", 1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00);
      rst = 1'b0; req_valid = 4'b1001; req_port = 8'hC3;
      cyc("t6_after", 1'b0, 4'b0001, 4'b1000, 8'h00, 8'h03);

      // tail_done on input 3 at the edge that samples its pending request
      // is ignored; input 3 is then granted after the bubble.
      tail_done = 4'b1001;
      cyc("ht_rel", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000; req_valid = 4'b1000;
      cyc("ht_grant", 1'b0, 4'b1000, 4'b1000, 8'hC0, 8'hC0);
      req_valid = 4'b0000; tail_done = 4'b1000;
      cyc("ht_done", 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00);
      tail_done = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
